// File: rtl/video_window_crop.sv
`default_nettype none
// ============================================================================
//  Module   : video_window_crop
//  Purpose  : Counts pixel/line position from raw core syncs, cuts a fixed
//             WIDTH x HEIGHT active window with 1-clk output latency and
//             regenerates clean hblank/vblank for the rotation stage.
//             Optional geometry measurement and lock detection is built
//             when CROP_MEAS_EN is defined; otherwise locked reports 1 one
//             clock after reset release and the measurement outputs are 0.
//  Revision : 1.0  initial release
// ============================================================================
module video_window_crop #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 256,
    parameter int HEIGHT  = 224,
    parameter int H_START = 16,
    parameter int V_START = 16,
    parameter int CW      = 12
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             ce_in,
    input  logic [DEPTH-1:0] video_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic             ce_out,
    output logic [DEPTH-1:0] video_out,
    output logic             hblank,
    output logic             vblank,
    output logic [CW-1:0]    line_len,
    output logic [CW-1:0]    frame_lines,
    output logic             locked
);

    // Window bounds carry one extra bit so H_START+WIDTH never truncates.
    localparam logic [CW:0]   c_h_lo      = (CW+1)'(H_START);
    localparam logic [CW:0]   c_h_hi      = (CW+1)'(H_START + WIDTH);
    localparam logic [CW:0]   c_v_lo      = (CW+1)'(V_START);
    localparam logic [CW:0]   c_v_hi      = (CW+1)'(V_START + HEIGHT);
    localparam logic [CW-1:0] c_cnt_max   = '1;
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    logic          r_hs_d;
    logic          r_vs_d;
    logic          r_frame_valid;
    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;

    logic          w_hs_rise;
    logic          w_vs_rise;
    logic          w_h_act;
    logic          w_v_act;
    logic [CW-1:0] w_hcnt_inc;
    logic [CW-1:0] w_vcnt_inc;

    assign w_hs_rise  = hsync_in & ~r_hs_d;
    assign w_vs_rise  = vsync_in & ~r_vs_d;

    // Saturating +1 of the pre-update counters; also reused as the measured
    // geometry (count + 1 = number of samples in the line/frame).
    assign w_hcnt_inc = (r_hcnt == c_cnt_max) ? r_hcnt : r_hcnt + c_cnt_one;
    assign w_vcnt_inc = (r_vcnt == c_cnt_max) ? r_vcnt : r_vcnt + c_cnt_one;

    // A saturated counter is never inside the window, even if the window
    // bounds happen to reach the top of the counter range.
    assign w_h_act = ({1'b0, r_hcnt} >= c_h_lo) && ({1'b0, r_hcnt} < c_h_hi) &&
                     (r_hcnt != c_cnt_max);
    // Vertical position is meaningless until a vsync edge has been seen,
    // so no window line is emitted between reset release and that edge.
    assign w_v_act = r_frame_valid &&
                     ({1'b0, r_vcnt} >= c_v_lo) && ({1'b0, r_vcnt} < c_v_hi) &&
                     (r_vcnt != c_cnt_max);

    // ce_out marks the clock on which the output register holds a new sample.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ce_out <= 1'b0;
        end else begin
            ce_out <= ce_in;
        end
    end

    // Sync history and position counters; vs_rise overrides the hs_rise
    // line increment so a coincident hsync/vsync starts at line 0.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_frame_valid <= 1'b0;
        end else if (ce_in) begin
            r_hs_d <= hsync_in;
            r_vs_d <= vsync_in;
            if (w_hs_rise) begin
                r_hcnt <= '0;
            end else begin
                r_hcnt <= w_hcnt_inc;
            end
            if (w_vs_rise) begin
                r_vcnt        <= '0;
                r_frame_valid <= 1'b1;
            end else if (w_hs_rise) begin
                r_vcnt <= w_vcnt_inc;
            end
        end
    end

    // Output register: blanking flags and pixel gated to the window.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hblank    <= 1'b1;
            vblank    <= 1'b1;
            video_out <= '0;
        end else if (ce_in) begin
            hblank    <= ~w_h_act;
            vblank    <= ~w_v_act;
            video_out <= (w_h_act && w_v_act) ? video_in : '0;
        end
    end

`ifdef CROP_MEAS_EN
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    lock_state_t   r_state;
    lock_state_t   w_state_next;
    logic          w_latch_ref;
    logic          w_geom_match;
    logic [CW-1:0] w_geom_len;
    logic [CW-1:0] r_line_len;
    logic [CW-1:0] r_frame_lines;
    logic [CW-1:0] r_ref_len;
    logic [CW-1:0] r_ref_lines;

    // Geometry at a vs_rise uses the line length as updated in the same
    // sample, so a coincident hsync contributes the line it just closed.
    assign w_geom_len   = w_hs_rise ? w_hcnt_inc : r_line_len;
    assign w_geom_match = (w_geom_len == r_ref_len) && (w_vcnt_inc == r_ref_lines);

    // Line/frame length capture on sync edges.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_line_len    <= '0;
            r_frame_lines <= '0;
        end else if (ce_in) begin
            if (w_hs_rise) begin
                r_line_len <= w_hcnt_inc;
            end
            if (w_vs_rise) begin
                r_frame_lines <= w_vcnt_inc;
            end
        end
    end

    // Lock state and reference geometry registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_UNLOCKED;
            r_ref_len   <= '0;
            r_ref_lines <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch_ref) begin
                r_ref_len   <= w_geom_len;
                r_ref_lines <= w_vcnt_inc;
            end
        end
    end

    // Lock transitions, evaluated only on a vs_rise sample.
    always_comb begin
        w_state_next = r_state;
        w_latch_ref  = 1'b0;
        if (ce_in && w_vs_rise) begin
            case (r_state)
                ST_UNLOCKED: begin
                    w_state_next = ST_CHECK;
                    w_latch_ref  = 1'b1;
                end
                ST_CHECK: begin
                    if (w_geom_match) begin
                        w_state_next = ST_LOCKED;
                    end else begin
                        w_latch_ref  = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_geom_match) begin
                        w_state_next = ST_UNLOCKED;
                    end
                end
                default: begin
                    w_state_next = ST_UNLOCKED;
                end
            endcase
        end
    end

    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign locked      = (r_state == ST_LOCKED);
`else
    logic r_locked;

    // Without measurement the source is assumed good once out of reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
        end else begin
            r_locked <= 1'b1;
        end
    end

    assign line_len    = '0;
    assign frame_lines = '0;
    assign locked      = r_locked;
`endif

endmodule
`default_nettype wire
